// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Contents: funct3 access-size codes for loads and stores, the 2-bit FSM state
// encoding, and the byte-enable width used on the data-memory bus.
package mem_access_stage_pkg;

    localparam int unsigned BE_W = 4;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem_access_stage_load_format.sv
// mem_load_format: combinational lane select and sign/zero extension of a
// 32-bit read word.
// Ports:
//   rdata_i  - raw word from memory
//   off_i    - byte offset of the access within the word
//   funct3_i - load size/sign code
//   data_o   - formatted 32-bit load result
module mem_load_format
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage. Issues loads/stores on a req/ack data
// memory bus with byte-lane steering, formats load data, stalls upstream while
// an access is outstanding and forwards the write-back payload to MEM/WB.
// Ports:
//   sys_clk_i, rst_i           - clock, synchronous active-high reset
//   valid_i .. rd_i            - EX/MEM register contents
//   dm_*                       - data memory bus (word address, byte enables)
//   stall_o                    - freeze upstream, bubble into MEM/WB
//   DM_rd_data_o .. rd_o       - write-back payload
//   mem_exc_o                  - pulse after an illegal memory op
//   bus_err_o                  - pulse in DONE when the access timed out
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic            sys_clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [31:0]     alu_result_i,
    input  logic [31:0]     rs2_data_i,
    input  logic            MemRead_i,
    input  logic            MemWrite_i,
    input  logic [2:0]      funct3_i,
    input  logic            RegWrite_i,
    input  logic            MemtoReg_i,
    input  logic [4:0]      rd_i,
    output logic            dm_req_o,
    output logic            dm_we_o,
    output logic [31:0]     dm_addr_o,
    output logic [31:0]     dm_wdata_o,
    output logic [BE_W-1:0] dm_be_o,
    input  logic [31:0]     dm_rdata_i,
    input  logic            dm_ack_i,
    output logic            stall_o,
    output logic [31:0]     DM_rd_data_o,
    output logic [31:0]     alu_result_o,
    output logic            RegWrite_o,
    output logic            MemtoReg_o,
    output logic [4:0]      rd_o,
    output logic            mem_exc_o,
    output logic            bus_err_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [BE_W-1:0] be_q, be_d;
    logic            we_q, we_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      f3_q, f3_d;
    logic            err_q, err_d;
    logic            exc_q, exc_d;

    logic [1:0]      off;
    logic            mem_op;
    logic            illegal;
    logic            bad_f3;
    logic            exc_now;
    logic            timeout_now;
    logic [BE_W-1:0] be_n;
    logic [31:0]     wdata_n;
    logic [31:0]     fmt_data;

    assign off    = alu_result_i[1:0];
    assign mem_op = valid_i & (MemRead_i | MemWrite_i);

    // Lane select uses the registered offset/size so the result tracks the
    // access actually on the bus, not whatever EX/MEM currently holds.
    mem_load_format u_load_format (
        .rdata_i  (dm_rdata_i),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (fmt_data)
    );

    // Legality check
    always_comb begin
        bad_f3 = 1'b0;
        if (MemRead_i) begin
            case (funct3_i)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: bad_f3 = 1'b0;
                default:                             bad_f3 = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_SB, F3_SH, F3_SW: bad_f3 = 1'b0;
                default:             bad_f3 = 1'b1;
            endcase
        end
        illegal = (MemRead_i & MemWrite_i) | bad_f3;
        if (funct3_i[1:0] == 2'b01 && off[0]) begin
            illegal = 1'b1;
        end
        if (funct3_i[1:0] == 2'b10 && off != 2'b00) begin
            illegal = 1'b1;
        end
    end

    // Store lane steering; loads read the whole word
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = 32'd0;
        if (MemWrite_i) begin
            case (funct3_i)
                F3_SB: begin
                    wdata_n = {4{rs2_data_i[7:0]}};
                    be_n    = 4'b0001 << off;
                end
                F3_SH: begin
                    wdata_n = {2{rs2_data_i[15:0]}};
                    be_n    = 4'b0011 << off;
                end
                default: begin
                    wdata_n = rs2_data_i;
                    be_n    = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        be_d     = be_q;
        we_d     = we_q;
        off_d    = off_q;
        f3_d     = f3_q;
        err_d    = err_q;
        exc_d    = 1'b0;
        stall_o  = 1'b0;
        dm_req_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    if (illegal) begin
                        exc_d = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        addr_d  = {alu_result_i[31:2], 2'b00};
                        we_d    = MemWrite_i;
                        be_d    = be_n;
                        wdata_d = wdata_n;
                        off_d   = off;
                        f3_d    = funct3_i;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        rdata_d = 32'd0;
                        stall_o = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                stall_o  = 1'b1;
                dm_req_o = 1'b1;
                // Ack is checked first so a same-cycle ack beats the timeout
                if (dm_ack_i) begin
                    rdata_d = fmt_data;
                    state_d = ST_DONE;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            be_q    <= '0;
            we_q    <= 1'b0;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            err_q   <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            err_q   <= err_d;
            exc_q   <= exc_d;
        end
    end

    assign exc_now     = (state_q == ST_IDLE) & mem_op & illegal;
    assign timeout_now = (state_q == ST_DONE) & err_q;

    assign dm_we_o      = we_q & dm_req_o;
    assign dm_addr_o    = addr_q;
    assign dm_wdata_o   = wdata_q;
    assign dm_be_o      = be_q;
    assign DM_rd_data_o = rdata_q;
    assign mem_exc_o    = exc_q;
    assign bus_err_o    = timeout_now;

    assign alu_result_o = alu_result_i;
    assign rd_o         = rd_i;
    assign MemtoReg_o   = MemtoReg_i;
    assign RegWrite_o   = RegWrite_i & valid_i & ~stall_o & ~exc_now & ~timeout_now;

endmodule
